pe_command_sequencer: RTL and testbench
=======================================

# pe_command_sequencer

Controller that drives the command/handshake port of a `message_passer` processing element, or of a PE array whose per-PE `ready` lines are ANDed. On `start`, it issues a fixed matrix-multiply schedule: an optional clear, then `N_STEPS` rounds of multiply-accumulate, shift-right and shift-down. Each command completes on the PE's `ack`/`ready` four-phase handshake before the next is issued. It sits between the host control logic and the PE fabric, replacing testbench-style manual command sequencing.

## Interface
Parameters:
- `N_STEPS`, 4: number of MAC/shift rounds per run; legal range 0..255.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles; used only with `SEQ_TIMEOUT_EN`.

Ports:
- `CLK` input 1: system clock; all logic on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `start` input 1: begin a run; sampled only in IDLE.
- `accumulate` input 1: sampled with `start`; 1 skips the initial clear, so results add onto the existing `s_out`.
- `ready` input 1: PE (or AND of array) completion flag.
- `ack` output 1: PE handshake. 0 = execute the command; 1 = release.
- `command_to_execute` output 3: PE opcode.
- `busy` output 1: high from the cycle after an accepted `start` until DONE exits.
- `done` output 1: one-cycle pulse when a run completes.
- `step` output 8: number of completed rounds in the current run.
- `error` output 1: watchdog fired; sticky until `RST`. Tied to 0 without `SEQ_TIMEOUT_EN`.

## Operation
- Opcodes used:
  - CLEAR = 3'b111
  - MAC = 3'b000
  - SHR = 3'b100
  - SHD = 3'b010
- Schedule is `[CLEAR]` followed by (MAC, SHR, SHD) × `N_STEPS`. CLEAR is omitted when `accumulate`=1.
- Total ops = 3·`N_STEPS` + (`accumulate` ? 0 : 1).
- Internal op index counts 0..2 within a round. `step` increments after each completed SHD.
- States:
  - IDLE: `busy`=0, `ack`=1. On `start`, latch `accumulate` and load the first opcode → ISSUE.
    - If total ops = 0 (`N_STEPS`=0 with `accumulate`=1), go directly to DONE instead.
  - ISSUE: wait for `ready`=0 (PE released). Then register `ack`<=0 → WAIT_DONE. `command_to_execute` stays stable for the whole ISSUE..RELEASE span.
  - WAIT_DONE: wait for `ready`=1. Then `ack`<=1 → RELEASE.
  - RELEASE: wait for `ready`=0.
    - If this was the last op → DONE.
    - Otherwise load the next opcode → ISSUE.
  - DONE: `done`=1 for one cycle → IDLE. `step` holds its final value until the next accepted `start`, which clears it to 0.
  - ERR (`SEQ_TIMEOUT_EN` only): `ack`=1, `error`=1, `busy`=0. Exits only on `RST`.
- `start` while `busy` is ignored. No queueing.
- Reset values: `ack`=1, `command_to_execute`=3'b000, `busy`=0, `done`=0, `step`=0, `error`=0, state IDLE.
- `RST` asserted mid-run aborts the run immediately. `ack` returns to 1 on the next edge so the PE completes its release. No partial `done` is produced.
- `ready` glitches in ISSUE while `ready`=1 persist: the block stalls indefinitely without the watchdog. This is legal.

## Timing
- All outputs are registered; nothing is combinational from the inputs.
- `start` accepted at edge k → `busy`=1 and first opcode valid at k+1.
  - Earliest `ack`=0 is at k+2, when `ready`=0 is already sampled at k+1.
- Minimum cost per op is 3 cycles (ISSUE, WAIT_DONE, RELEASE), each with a zero-wait PE response.
- Run latency = Σ(3 + PE wait cycles) + 1 (DONE).
- `ack` changes only on state transitions. Opcode changes only on the RELEASE→ISSUE edge or the IDLE→ISSUE edge, never while `ack`=0.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A cycle counter resets on every state entry.
  - If the block spends `TIMEOUT_CYCLES` consecutive cycles in ISSUE, WAIT_DONE or RELEASE, it enters ERR.
- `SEQ_TIMEOUT_EN` undefined:
  - No counter and no ERR state; `error` is constant 0.
  - Waits are unbounded.

## Test plan
- Default run. Setup: `N_STEPS`=4, `accumulate`=0, PE model raises `ready` 2 cycles after `ack` falls and drops it 1 cycle after `ack` rises. Required:
  - Opcode sequence 111, then (000, 100, 010)×4.
  - 13 `ack` low pulses.
  - `step` progresses 0→4.
  - `done` pulses once; `busy` is low afterward.
- Accumulate run. Setup: `N_STEPS`=2, `accumulate`=1. Required: ops 000, 100, 010, 000, 100, 010 with no 111; `done` after 6 handshakes.
- Degenerate runs. Required:
  - `N_STEPS`=0, `accumulate`=0: only 111 is issued, then `done`.
  - `N_STEPS`=0, `accumulate`=1: `done` at k+2 with no `ack` pulse.
- Start while busy. Stimulus: pulse `start` during the 5th op. Required: schedule unchanged; exactly one `done`.
- Reset mid-run. Stimulus: assert `RST` during WAIT_DONE of op 3. Required: next cycle `ack`=1, `busy`=0, `step`=0, `command_to_execute`=000; a new `start` replays from CLEAR.
- Watchdog (`SEQ_TIMEOUT_EN`). Stimulus: PE model never raises `ready`, `TIMEOUT_CYCLES`=64. Required: `error`=1 exactly 64 cycles after entering WAIT_DONE; `ack`=1; `busy`=0; `start` ignored until `RST`.

Source files
------------

// File: rtl/pe_command_sequencer.sv
`default_nettype none
// ============================================================================
// pe_command_sequencer
//   Issues [CLEAR] + (MAC, SHR, SHD) x N_STEPS to a PE over its ack/ready
//   four-phase handshake. Optional watchdog: define SEQ_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module pe_command_sequencer #(
   parameter int N_STEPS        = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic       accumulate,
   input  logic       ready,
   output logic       ack,
   output logic [2:0] command_to_execute,
   output logic       busy,
   output logic       done,
   output logic [7:0] step,
   output logic       error
);

   localparam logic [2:0] C_OP_CLEAR  = 3'b111;
   localparam logic [2:0] C_OP_MAC    = 3'b000;
   localparam logic [2:0] C_OP_SHR    = 3'b100;
   localparam logic [2:0] C_OP_SHD    = 3'b010;
   localparam logic [7:0] C_LAST_STEP = 8'(N_STEPS - 1);
   localparam logic       C_HAS_STEPS = (N_STEPS != 0);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_RELEASE   = 3'd3,
      S_DONE      = 3'd4
`ifdef SEQ_TIMEOUT_EN
      , S_ERR     = 3'd5
`endif
   } state_t;

   state_t     r_state;
   logic       r_is_clear;
   logic [1:0] r_op_idx;
   logic       w_last;

   function automatic logic [2:0] round_op(input logic [1:0] idx);
      case (idx)
         2'd0:    return C_OP_MAC;
         2'd1:    return C_OP_SHR;
         default: return C_OP_SHD;
      endcase
   endfunction

   // CLEAR is last only when there are no rounds; otherwise the final SHD is.
   assign w_last = r_is_clear ? !C_HAS_STEPS
                              : (r_op_idx == 2'd2 && step == C_LAST_STEP);

`ifdef SEQ_TIMEOUT_EN
   localparam int C_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [C_WD_W-1:0] r_wd_cnt;
   logic              w_advance;
   logic              w_in_wait;

   assign w_in_wait = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE) ||
                      (r_state == S_RELEASE);
   assign w_advance = (r_state == S_IDLE && start) || (r_state == S_DONE) ||
                      (r_state == S_ISSUE && !ready) ||
                      (r_state == S_WAIT_DONE && ready) ||
                      (r_state == S_RELEASE && !ready);
`else
   assign error = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state            <= S_IDLE;
         r_is_clear         <= 1'b0;
         r_op_idx           <= 2'd0;
         ack                <= 1'b1;
         command_to_execute <= 3'b000;
         busy               <= 1'b0;
         done               <= 1'b0;
         step               <= 8'd0;
`ifdef SEQ_TIMEOUT_EN
         error              <= 1'b0;
         r_wd_cnt           <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  busy               <= 1'b1;
                  step               <= 8'd0;
                  r_op_idx           <= 2'd0;
                  r_is_clear         <= !accumulate;
                  command_to_execute <= accumulate ? C_OP_MAC : C_OP_CLEAR;
                  r_state            <= (accumulate && !C_HAS_STEPS) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!ready) begin
                  ack     <= 1'b0;
                  r_state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (ready) begin
                  ack     <= 1'b1;
                  r_state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (!ready) begin
                  if (!r_is_clear && r_op_idx == 2'd2)
                     step <= step + 8'd1;
                  if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state    <= S_ISSUE;
                     r_is_clear <= 1'b0;
                     if (r_is_clear || r_op_idx == 2'd2) begin
                        r_op_idx           <= 2'd0;
                        command_to_execute <= C_OP_MAC;
                     end else begin
                        r_op_idx           <= r_op_idx + 2'd1;
                        command_to_execute <= round_op(r_op_idx + 2'd1);
                     end
                  end
               end
            end
            S_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
`ifdef SEQ_TIMEOUT_EN
            S_ERR: begin
               ack  <= 1'b1;
               busy <= 1'b0;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
`ifdef SEQ_TIMEOUT_EN
         // Counter measures time spent in the current state; timeout wins over a same-cycle advance.
         r_wd_cnt <= w_advance ? '0 : r_wd_cnt + 1'b1;
         if (w_in_wait && r_wd_cnt == C_WD_W'(TIMEOUT_CYCLES - 1)) begin
            r_state <= S_ERR;
            ack     <= 1'b1;
            busy    <= 1'b0;
            error   <= 1'b1;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pe_command_sequencer.sv
`default_nettype none
// Self-checking bench for pe_command_sequencer: three instances (N_STEPS 4/2/0)
// each driven by a small PE responder and checked against a schedule model.
module tb_pe_command_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start [3] = '{default: 1'b0};
   logic       accm  [3] = '{default: 1'b0};
   logic       ready [3] = '{default: 1'b0};
   logic       ack   [3];
   logic       busy  [3];
   logic       done  [3];
   logic       error [3];
   logic [2:0] cmd   [3];
   logic [7:0] step  [3];

   int         ns [3] = '{4, 2, 0};
   bit         stall [3] = '{default: 1'b0};
   int         lowcnt [3] = '{default: 0};
   int         nops [3] = '{default: 0};
   int         dones [3] = '{default: 0};
   int         fall_cyc [3] = '{default: 0};
   bit         run_acc [3] = '{default: 1'b0};
   bit         prev_ack [3] = '{default: 1'b1};
   logic [2:0] held_op [3];
   logic [7:0] prev_step [3] = '{default: 8'd0};
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   pe_command_sequencer #(.N_STEPS(4), .TIMEOUT_CYCLES(64)) u_n4 (
      .CLK(clk), .RST(rst), .start(start[0]), .accumulate(accm[0]), .ready(ready[0]),
      .ack(ack[0]), .command_to_execute(cmd[0]), .busy(busy[0]), .done(done[0]),
      .step(step[0]), .error(error[0]));

   pe_command_sequencer #(.N_STEPS(2), .TIMEOUT_CYCLES(64)) u_n2 (
      .CLK(clk), .RST(rst), .start(start[1]), .accumulate(accm[1]), .ready(ready[1]),
      .ack(ack[1]), .command_to_execute(cmd[1]), .busy(busy[1]), .done(done[1]),
      .step(step[1]), .error(error[1]));

   pe_command_sequencer #(.N_STEPS(0), .TIMEOUT_CYCLES(64)) u_n0 (
      .CLK(clk), .RST(rst), .start(start[2]), .accumulate(accm[2]), .ready(ready[2]),
      .ack(ack[2]), .command_to_execute(cmd[2]), .busy(busy[2]), .done(done[2]),
      .step(step[2]), .error(error[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Schedule model: op j of a run, from the CLEAR/round rules.
   function automatic logic [2:0] exp_op(input bit acc, input int j);
      int r;
      if (!acc) begin
         if (j == 0) return 3'b111;
         r = (j - 1) % 3;
      end else begin
         r = j % 3;
      end
      case (r)
         0:       return 3'b000;
         1:       return 3'b100;
         default: return 3'b010;
      endcase
   endfunction

   function automatic int total(input int i, input bit acc);
      return 3 * ns[i] + (acc ? 0 : 1);
   endfunction

   always @(posedge clk) cyc++;

   // PE responder: ready rises 2 cycles after ack falls, drops once ack rises.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (ack[i] === 1'b0) begin
            lowcnt[i]++;
            if (lowcnt[i] >= 2 && !stall[i]) ready[i] = 1'b1;
         end else begin
            lowcnt[i] = 0;
            ready[i]  = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (prev_ack[i] && ack[i] === 1'b0) begin
               check("op_seq", {29'd0, cmd[i]}, {29'd0, exp_op(run_acc[i], nops[i])});
               check("op_count", 32'(nops[i] < total(i, run_acc[i])), 32'd1);
               held_op[i]  = cmd[i];
               fall_cyc[i] = cyc;
               nops[i]++;
            end else if (!prev_ack[i] && ack[i] === 1'b0) begin
               check("op_stable", {29'd0, cmd[i]}, {29'd0, held_op[i]});
            end
            if (busy[i] !== 1'b1) check("ack_idle", {31'd0, ack[i]}, 32'd1);
            if (step[i] !== prev_step[i] && step[i] !== 8'd0)
               check("step_incr", {24'd0, step[i]}, 32'(prev_step[i]) + 32'd1);
            if (done[i] === 1'b1) begin
               check("done_ops", nops[i], total(i, run_acc[i]));
               check("done_step", {24'd0, step[i]}, ns[i]);
               check("done_busy", {31'd0, busy[i]}, 32'd0);
               dones[i]++;
            end
`ifndef SEQ_TIMEOUT_EN
            check("error_tied", {31'd0, error[i]}, 32'd0);
`endif
            prev_ack[i]  = ack[i];
            prev_step[i] = step[i];
         end
      end
   end

   task automatic do_start(input int i, input bit acc);
      @(posedge clk); #2;
      accm[i] = acc; start[i] = 1'b1; run_acc[i] = acc; nops[i] = 0;
      @(posedge clk); #2;
      start[i] = 1'b0; accm[i] = 1'b0;
      check("start_busy", {31'd0, busy[i]}, 32'd1);
      check("start_op", {29'd0, cmd[i]}, {29'd0, exp_op(acc, 0)});
      check("start_ack", {31'd0, ack[i]}, 32'd1);
      check("start_step", {24'd0, step[i]}, 32'd0);
   endtask

   task automatic wait_done(input int i, input int d0);
      int c = 0;
      while (dones[i] == d0 && c < 2000) begin
         @(negedge clk); #1;
         c++;
      end
      check("run_done", 32'(dones[i] != d0), 32'd1);
   endtask

   task automatic wait_ops(input int i, input int n);
      int c = 0;
      while (nops[i] < n && c < 500) begin
         @(negedge clk); #1;
         c++;
      end
      check("ops_reached", 32'(nops[i] >= n), 32'd1);
   endtask

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #2;
      check("rst_ack",  {31'd0, ack[0]},  32'd1);
      check("rst_cmd",  {29'd0, cmd[0]},  32'd0);
      check("rst_busy", {31'd0, busy[0]}, 32'd0);
      check("rst_done", {31'd0, done[0]}, 32'd0);
      check("rst_step", {24'd0, step[0]}, 32'd0);
      check("rst_err",  {31'd0, error[0]}, 32'd0);

      // Default run: CLEAR + 4 rounds.
      d0 = dones[0];
      do_start(0, 1'b0);
      check("first_op_clear", {29'd0, cmd[0]}, 32'h7);
      wait_done(0, d0);
      check("default_ops", nops[0], 13);
      check("default_step", {24'd0, step[0]}, 32'd4);
      @(negedge clk);
      check("default_busy_after", {31'd0, busy[0]}, 32'd0);

      // Accumulate run on N_STEPS=2.
      d0 = dones[1];
      do_start(1, 1'b1);
      check("acc_first_mac", {29'd0, cmd[1]}, 32'h0);
      wait_done(1, d0);
      check("acc_ops", nops[1], 6);

      // N_STEPS=0, clear only.
      d0 = dones[2];
      do_start(2, 1'b0);
      wait_done(2, d0);
      check("n0_clear_ops", nops[2], 1);

      // N_STEPS=0 with accumulate: done at k+2, no handshake.
      d0 = dones[2];
      do_start(2, 1'b1);
      @(posedge clk); #2;
      check("n0acc_done", {31'd0, done[2]}, 32'd1);
      check("n0acc_busy", {31'd0, busy[2]}, 32'd0);
      check("n0acc_ack",  {31'd0, ack[2]},  32'd1);
      @(negedge clk); #1;
      check("n0acc_ops", nops[2], 0);
      check("n0acc_one_done", dones[2] - d0, 1);

      // Start while busy is ignored.
      d0 = dones[0];
      do_start(0, 1'b0);
      wait_ops(0, 5);
      @(posedge clk); #2;
      start[0] = 1'b1; accm[0] = 1'b1;
      @(posedge clk); #2;
      start[0] = 1'b0; accm[0] = 1'b0;
      wait_done(0, d0);
      check("busy_start_ops", nops[0], 13);
      repeat (30) @(negedge clk);
      #1;
      check("busy_start_dones", dones[0] - d0, 1);
      check("busy_start_no_more_ops", nops[0], 13);

      // Reset during WAIT_DONE of op 3, then replay.
      d0 = dones[0];
      do_start(0, 1'b0);
      wait_ops(0, 3);
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      check("midrst_ack",  {31'd0, ack[0]},  32'd1);
      check("midrst_busy", {31'd0, busy[0]}, 32'd0);
      check("midrst_step", {24'd0, step[0]}, 32'd0);
      check("midrst_cmd",  {29'd0, cmd[0]},  32'd0);
      check("midrst_no_done", dones[0] - d0, 0);
      d0 = dones[0];
      do_start(0, 1'b0);
      check("replay_clear", {29'd0, cmd[0]}, 32'h7);
      wait_done(0, d0);
      check("replay_ops", nops[0], 13);

`ifdef SEQ_TIMEOUT_EN
      // Watchdog: PE never raises ready.
      stall[0] = 1'b1;
      do_start(0, 1'b0);
      wait_ops(0, 1);
      begin
         int c = 0;
         while (error[0] !== 1'b1 && c < 200) begin
            @(negedge clk); #1;
            c++;
         end
      end
      check("wd_error", {31'd0, error[0]}, 32'd1);
      check("wd_latency", cyc - fall_cyc[0], 64);
      check("wd_ack",  {31'd0, ack[0]},  32'd1);
      check("wd_busy", {31'd0, busy[0]}, 32'd0);
      @(posedge clk); #2;
      start[0] = 1'b1;
      @(posedge clk); #2;
      start[0] = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("wd_sticky", {31'd0, error[0]}, 32'd1);
      check("wd_start_ignored", {31'd0, busy[0]}, 32'd0);
      stall[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      check("wd_cleared", {31'd0, error[0]}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
